// File: rtl/rom_reader_pkg.sv
// Shared types and constants for the ROM frame reader.
// BYTE_UNPACK_EN narrows the pixel stream to 8 bits and emits two beats per word.
package rom_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [15:0] data;
    logic        sof;
    logic        eol;
    logic        eof;
  } fifo_entry_t;

  // ROM returns data exactly this many cycles after an issue cycle.
  localparam int RD_LATENCY = 1;

`ifdef BYTE_UNPACK_EN
  localparam int PIX_W = 8;
`else
  localparam int PIX_W = 16;
`endif

endpackage

// File: rtl/rom_reader_fifo.sv
// Small synchronous FIFO with occupancy count and a single-cycle flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module rom_reader_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((count < CAP) || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush discards everything, including a same-cycle push.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; no reset needed since reads are qualified by empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rom_frame_reader.sv
// Sweeps an on-chip image ROM once per start and streams the words to the
// display pipeline over valid/ready with sof/eol/eof tags.
// Optional BYTE_UNPACK_EN: 8-bit output, low byte then high byte per word.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | issuing ROM reads while FIFO credit allows
// DRAIN | all reads issued; waiting for the eof word to be accepted
module rom_frame_reader
  import rom_reader_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int DEPTH      = 4096,
  parameter int LINE_WORDS = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic              m_clken,
  output logic              m_write,
  output logic [1:0]        m_byteenable,
  input  logic [15:0]       m_readdata,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              pix_eof
);

  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
  // Worst-case outstanding words: a full FIFO plus reads still in the ROM pipe.
  localparam int CRED_W = $clog2(FIFO_DEPTH + RD_LATENCY) + 1;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] issue_cnt;
  logic [ADDR_W-1:0] rd_word;
  logic              inflight;
  logic              issue;
  logic              last_issue;
  logic              start_ok;
  logic              abort_ok;
  logic              push;
  logic              pop;
  logic [FCNT_W-1:0] fifo_count;
  logic              fifo_empty;
  logic [CRED_W-1:0] credit_used;
  fifo_entry_t       push_entry;
  fifo_entry_t       head;

  assign abort_ok    = abort && (state != IDLE);
  assign start_ok    = start && !abort && (state == IDLE);
  assign credit_used = CRED_W'(fifo_count) + CRED_W'(inflight);
  assign issue       = (state == FETCH) && !abort && (credit_used < CRED_W'(FIFO_DEPTH));
  assign last_issue  = issue && (issue_cnt == ADDR_W'(DEPTH - 1));
  assign push        = inflight && !abort_ok;

  assign m_address    = issue ? issue_cnt : '0;
  assign m_chipselect = issue;
  assign m_clken      = issue;
  assign m_write      = 1'b0;
  assign m_byteenable = 2'b11;

  // Tag the returning word using the address that was issued one cycle earlier.
  always_comb begin
    push_entry      = '0;
    push_entry.data = m_readdata;
    push_entry.sof  = (rd_word == '0);
    push_entry.eol  = ((32'(rd_word) % LINE_WORDS) == (LINE_WORDS - 1));
    push_entry.eof  = (rd_word == ADDR_W'(DEPTH - 1));
  end

  rom_reader_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (abort_ok),
    .din     (push_entry),
    .dout    (head),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

  assign pix_valid = !fifo_empty;

`ifdef BYTE_UNPACK_EN
  logic byte_sel;

  // Alternates low/high byte on each accepted beat; restarts on abort.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    byte_sel <= 1'b0;
    else if (abort_ok)               byte_sel <= 1'b0;
    else if (pix_valid && pix_ready) byte_sel <= ~byte_sel;
  end

  assign pop      = pix_valid && pix_ready && byte_sel;
  assign pix_data = byte_sel ? head.data[15:8] : head.data[7:0];
  assign pix_sof  = pix_valid && !byte_sel && head.sof;
  assign pix_eol  = pix_valid && byte_sel && head.eol;
  assign pix_eof  = pix_valid && byte_sel && head.eof;
`else
  assign pop      = pix_valid && pix_ready;
  assign pix_data = head.data;
  assign pix_sof  = pix_valid && head.sof;
  assign pix_eol  = pix_valid && head.eol;
  assign pix_eof  = pix_valid && head.eof;
`endif

  // The eof word leaving the FIFO is necessarily the last outstanding one.
  assign done = (state == DRAIN) && pop && head.eof && !abort;
  assign busy = (state != IDLE) && !done;

  // Issue counter restarts on every accepted start and parks on the last word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                     issue_cnt <= '0;
    else if (start_ok)                issue_cnt <= '0;
    else if (issue && !last_issue)    issue_cnt <= issue_cnt + 1'b1;
  end

  // Track the single read in the ROM pipe and the address it belongs to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight <= 1'b0;
      rd_word  <= '0;
    end else begin
      inflight <= issue;
      if (issue) rd_word <= issue_cnt;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; abort takes priority over everything else.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_ok) state_nxt = FETCH;
      end
      FETCH: begin
        if (abort)           state_nxt = IDLE;
        else if (last_issue) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (abort || done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rom_frame_reader.sv
// Self-checking bench for rom_frame_reader (DEPTH=16, LINE_WORDS=4, FIFO_DEPTH=4).
`timescale 1ns/1ps
module tb_rom_frame_reader;
  import rom_reader_pkg::*;

  localparam int ADDR_W     = 12;
  localparam int DEPTH      = 16;
  localparam int LINE_WORDS = 4;
  localparam int FIFO_DEPTH = 4;
`ifdef BYTE_UNPACK_EN
  localparam int BPW = 2;
`else
  localparam int BPW = 1;
`endif
  localparam int NBEATS = DEPTH * BPW;

  typedef struct packed {
    logic [PIX_W-1:0] data;
    logic             sof;
    logic             eol;
    logic             eof;
  } beat_t;

  typedef struct {
    int          beat;
    logic [15:0] data;
    logic        sof;
    logic        eol;
    logic        eof;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] m_address;
  logic              m_chipselect;
  logic              m_clken;
  logic              m_write;
  logic [1:0]        m_byteenable;
  logic [15:0]       m_readdata;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_sof;
  logic              pix_eol;
  logic              pix_eof;

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t sb_q[$];
  beat_t cap[NBEATS];
  int    issued = 0;
  int    popped_words = 0;
  int    beat_idx = 0;
  int    done_cnt = 0;
  logic  stall_prev = 1'b0;
  beat_t held;
  vec_t  spot[6];

  always #5 clk = ~clk;

  rom_frame_reader #(
    .ADDR_W     (ADDR_W),
    .DEPTH      (DEPTH),
    .LINE_WORDS (LINE_WORDS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_clken      (m_clken),
    .m_write      (m_write),
    .m_byteenable (m_byteenable),
    .m_readdata   (m_readdata),
    .pix_data     (pix_data),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .pix_sof      (pix_sof),
    .pix_eol      (pix_eol),
    .pix_eof      (pix_eof)
  );

  function automatic logic [15:0] rom_word(input int a);
`ifdef BYTE_UNPACK_EN
    if (a == 0) return 16'hA1B2;
`endif
    return 16'(a * 3);
  endfunction

  function automatic beat_t make_beat(input int w, input int half);
    beat_t       b;
    logic [15:0] d;
    d = rom_word(w);
`ifdef BYTE_UNPACK_EN
    b.data = (half == 0) ? d[7:0] : d[15:8];
    b.sof  = (w == 0) && (half == 0);
    b.eol  = (half == 1) && ((w % LINE_WORDS) == LINE_WORDS - 1);
    b.eof  = (half == 1) && (w == DEPTH - 1);
`else
    b.data = d;
    b.sof  = (w == 0) && (half == 0);
    b.eol  = ((w % LINE_WORDS) == LINE_WORDS - 1);
    b.eof  = (w == DEPTH - 1);
`endif
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One-cycle-latency ROM model.
  always @(posedge clk) begin
    if (m_clken && m_chipselect) m_readdata <= rom_word(int'(m_address));
  end

  // Monitor: issue checks, scoreboard pops, stall stability, done alignment.
  always @(negedge clk) begin
    beat_t act;
    if (!reset_n) begin
      stall_prev = 1'b0;
    end else begin
      act = '{pix_data, pix_sof, pix_eol, pix_eof};
      if (busy && !abort && issued < DEPTH)
        chk("issue_when_credit", m_clken, ((issued - popped_words) < FIFO_DEPTH));
      if (m_clken) begin
        chk("credit_limit", ((issued - popped_words) < FIFO_DEPTH), 1);
        chk("issue_addr", m_address, issued);
        chk("issue_cs", m_chipselect, 1);
        issued++;
      end
      if (stall_prev) begin
        chk("stall_valid", pix_valid, 1);
        chk("stall_stable", act, held);
      end
      if (pix_valid && pix_ready) begin
        chk("sb_nonempty", (sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          beat_t e;
          e = sb_q.pop_front();
          chk("pix_data", pix_data, e.data);
          chk("pix_sof", pix_sof, e.sof);
          chk("pix_eol", pix_eol, e.eol);
          chk("pix_eof", pix_eof, e.eof);
        end
        if (beat_idx < NBEATS) cap[beat_idx] = act;
        beat_idx++;
        if ((beat_idx % BPW) == 0) popped_words++;
      end
      if (done || (pix_valid && pix_ready && pix_eof))
        chk("done_on_eof", done, (pix_valid && pix_ready && pix_eof));
      if (done) done_cnt++;
      stall_prev = pix_valid && !pix_ready && !abort;
      held = act;
    end
  end

  task automatic sb_clear();
    sb_q.delete();
    issued = 0;
    popped_words = 0;
    beat_idx = 0;
  endtask

  task automatic start_sweep();
    sb_clear();
    for (int b = 0; b < NBEATS; b++) sb_q.push_back(make_beat(b / BPW, b % BPW));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input int pct, input int budget, output int cycles);
    int d0;
    d0 = done_cnt;
    cycles = 0;
    while (done_cnt == d0 && cycles < budget) begin
      pix_ready = ($urandom_range(99) < pct);
      @(posedge clk); #1;
      cycles++;
    end
    chk("done_seen", (done_cnt != d0), 1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    int d0;
    int ok;

`ifdef BYTE_UNPACK_EN
    spot[0] = '{0,  16'h00B2, 1'b1, 1'b0, 1'b0};
    spot[1] = '{1,  16'h00A1, 1'b0, 1'b0, 1'b0};
    spot[2] = '{2,  16'h0003, 1'b0, 1'b0, 1'b0};
    spot[3] = '{7,  16'h0000, 1'b0, 1'b1, 1'b0};
    spot[4] = '{30, 16'h002D, 1'b0, 1'b0, 1'b0};
    spot[5] = '{31, 16'h0000, 1'b0, 1'b1, 1'b1};
`else
    spot[0] = '{0,  16'd0,  1'b1, 1'b0, 1'b0};
    spot[1] = '{1,  16'd3,  1'b0, 1'b0, 1'b0};
    spot[2] = '{3,  16'd9,  1'b0, 1'b1, 1'b0};
    spot[3] = '{7,  16'd21, 1'b0, 1'b1, 1'b0};
    spot[4] = '{11, 16'd33, 1'b0, 1'b1, 1'b0};
    spot[5] = '{15, 16'd45, 1'b0, 1'b1, 1'b1};
`endif

    reset_n = 1'b0; start = 1'b0; abort = 1'b0; pix_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", m_address, 0);
    chk("rst_cs", m_chipselect, 0);
    chk("rst_clken", m_clken, 0);
    chk("rst_write", m_write, 0);
    chk("rst_be", m_byteenable, 2'b11);
    chk("rst_valid", pix_valid, 0);
    chk("rst_sof", pix_sof, 0);
    chk("rst_eol", pix_eol, 0);
    chk("rst_eof", pix_eof, 0);
    reset_n = 1'b1;
    idle_cycles(2);

    // Happy path with ready held high.
    pix_ready = 1'b1;
    start_sweep();
    wait_done(100, 40, cyc);
    chk("happy_latency_ok", (cyc <= 19), 1);
    chk("happy_sb_empty", sb_q.size(), 0);
    chk("happy_beats", beat_idx, NBEATS);
    chk("happy_busy_low", busy, 0);
    chk("happy_valid_low", pix_valid, 0);
    for (int i = 0; i < 6; i++) begin
      chk("spot_data", cap[spot[i].beat].data, spot[i].data);
      chk("spot_sof", cap[spot[i].beat].sof, spot[i].sof);
      chk("spot_eol", cap[spot[i].beat].eol, spot[i].eol);
      chk("spot_eof", cap[spot[i].beat].eof, spot[i].eof);
    end
    idle_cycles(3);

    // Backpressure at ~30% ready.
    start_sweep();
    wait_done(30, 3000, cyc);
    chk("bp_sb_empty", sb_q.size(), 0);
    chk("bp_beats", beat_idx, NBEATS);
    pix_ready = 1'b1;
    idle_cycles(3);

    // Start pulsed mid-FETCH is ignored.
    d0 = done_cnt;
    pix_ready = 1'b1;
    start_sweep();
    idle_cycles(5);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(100, 60, cyc);
    idle_cycles(20);
    chk("sib_one_done", done_cnt - d0, 1);
    chk("sib_sb_empty", sb_q.size(), 0);
    chk("sib_busy_low", busy, 0);
    chk("sib_valid_low", pix_valid, 0);

    // Abort after 5 accepted beats.
    start_sweep();
    pix_ready = 1'b1;
    cyc = 0;
    while (beat_idx < 5 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("abort_reached_5", (beat_idx >= 5), 1);
    d0 = done_cnt;
    abort = 1'b1;
    pix_ready = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0;
    sb_clear();
    chk("abort_valid_low", pix_valid, 0);
    chk("abort_busy_low", busy, 0);
    pix_ready = 1'b1;
    idle_cycles(10);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_still_idle", pix_valid, 0);
    start_sweep();
    wait_done(100, 40, cyc);
    chk("restart_beats", beat_idx, NBEATS);
    chk("restart_first_sof", cap[0].sof, 1);
    idle_cycles(3);

    // Async reset in DRAIN.
    start_sweep();
    pix_ready = 1'b1;
    cyc = 0;
    while (issued < DEPTH && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    pix_ready = 1'b0;
    idle_cycles(2);
    chk("drain_busy", busy, 1);
    chk("drain_valid", pix_valid, 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_valid", pix_valid, 0);
    chk("arst_clken", m_clken, 0);
    chk("arst_cs", m_chipselect, 0);
    chk("arst_addr", m_address, 0);
    chk("arst_sof", pix_sof, 0);
    chk("arst_eol", pix_eol, 0);
    chk("arst_eof", pix_eof, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    sb_clear();
    pix_ready = 1'b1;
    ok = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (pix_valid || busy) ok = 0;
    end
    chk("post_rst_quiet", ok, 1);

    // Normal sweep after reset.
    start_sweep();
    wait_done(100, 40, cyc);
    chk("post_rst_beats", beat_idx, NBEATS);
    idle_cycles(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_frame_reader.md
Name: rom_frame_reader

Overview:
- Avalon-MM read-side master that sweeps a 16-bit single-port on-chip ROM (start/title screen image, MIF-initialised) from word 0 to DEPTH-1.
- Streams each word out on a valid/ready pixel interface toward the VGA compositor.
- Holds a small internal FIFO so downstream backpressure never loses a word.
- Sits between the image ROM slave port and the display pipeline; software or the game FSM starts one sweep per frame.

Parameters:
- ADDR_W, 12, ROM word-address width
- DEPTH, 4096, words per sweep (≤ 2**ADDR_W)
- LINE_WORDS, 64, words per image line, used to generate end-of-line (eol)
- FIFO_DEPTH, 4, internal buffer entries (power of two, ≥ 2)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begin a sweep (ignored while busy)
- abort  in  1  one-cycle pulse; cancel the sweep in progress
- busy  out  1  high from the cycle after an accepted start until done or abort
- done  out  1  one-cycle pulse when the last word has been accepted downstream
- m_address  out  ADDR_W  ROM word address
- m_chipselect  out  1  ROM chip select
- m_clken  out  1  ROM clock enable; high only on issue cycles
- m_write  out  1  tied 0
- m_byteenable  out  2  tied 2'b11
- m_readdata  in  16  ROM data; valid exactly 1 cycle after an issue cycle
- pix_data  out  16  output word
- pix_valid  out  1  pix_data valid
- pix_ready  in  1  downstream accept
- pix_sof  out  1  qualifies word 0 of the sweep
- pix_eol  out  1  qualifies the last word of each line
- pix_eof  out  1  qualifies word DEPTH-1

Behaviour:
- Reset: busy=0, done=0, m_address=0, m_chipselect=0, m_clken=0, pix_valid=0, pix_sof=pix_eol=pix_eof=0. FIFO empty, FSM in IDLE.
- FSM states:
  - IDLE: start → FETCH, with issue counter=0 and inflight=0.
  - FETCH: issues reads; after word DEPTH-1 is issued → DRAIN.
  - DRAIN: waits until the FIFO is empty and no read is inflight, then pulses done and returns to IDLE.
- Issue rule: in FETCH, issue when fifo_count + inflight < FIFO_DEPTH.
  - An issue cycle drives m_chipselect=1, m_clken=1, m_address=issue counter.
  - The issue counter then increments.
  - Issue rate is one word per cycle while credit allows.
- Read latency: exactly 1 cycle. The cycle after an issue, m_readdata is pushed into the FIFO together with tag bits:
  - sof: word==0
  - eol: (word mod LINE_WORDS)==LINE_WORDS-1
  - eof: word==DEPTH-1
- inflight: 1-bit register, set on an issue cycle, cleared the following cycle.
- Output: pix_* reflect the FIFO head.
  - A pop occurs when pix_valid && pix_ready.
  - pix_data and tags stay stable while pix_valid && !pix_ready.
- Simultaneous push and pop: count unchanged. Full FIFO cannot occur with a push pending, by the credit rule.
- Counter range: the counter does not wrap within a sweep. It stops after DEPTH-1 and restarts at 0 on the next start.
- done: asserted in the cycle the eof word is popped; busy falls in the same cycle.
- abort (any state except IDLE):
  - Next cycle: FIFO flushed, pix_valid=0, FSM → IDLE, no done pulse.
  - Any read returning in that cycle is discarded.
- start and abort in the same cycle: abort wins; the FSM stays or goes IDLE.
- start while busy: ignored.
- Async reset mid-sweep: immediate return to reset values.

Optional Feature:
- Macro BYTE_UNPACK_EN.
- When defined:
  - pix_data is 8 bits wide.
  - Each ROM word yields two output beats: low byte first, then high byte.
  - sof is tagged on the first beat only; eol and eof on the second beat only.
  - A word is popped from the FIFO after its second beat is accepted.
- When undefined: one 16-bit beat per word, as above.

Decomposition:
- Shared package rom_reader_pkg holds:
  - the state enum (IDLE, FETCH, DRAIN)
  - the FIFO entry struct {data[15:0], sof, eol, eof}
  - constant RD_LATENCY=1
- One natural sub-module: rom_reader_fifo, a synchronous FIFO with push, pop, count, flush, parameterised by width and depth.

Test Plan:
- Happy path: pix_ready held 1, DEPTH=16, LINE_WORDS=4, ROM model returns addr*3.
  - Expect 16 beats with data 0,3,…,45.
  - sof on beat 0, eol on beats 3,7,11,15, eof on beat 15.
  - done 1 cycle after start plus ≤19 cycles.
- Backpressure: pix_ready toggles pseudo-randomly at 30% high.
  - No word lost or duplicated.
  - pix_data stable while stalled.
  - Never more than FIFO_DEPTH issues outstanding beyond pops.
  - m_clken=0 whenever credit is exhausted.
- Abort: abort after 5 accepted beats.
  - Next cycle pix_valid=0, busy=0, and no done pulse.
  - A following start restarts at address 0 with sof on the first beat.
- Start while busy: start pulsed mid-FETCH.
  - Ignored; the sweep continues and exactly one done pulse occurs.
- Reset: reset_n dropped mid-DRAIN.
  - All outputs at reset values asynchronously.
  - After release, no pix_valid until the next start.
- BYTE_UNPACK_EN: word 0xA1B2 at address 0.
  - Beats 0xB2 (sof) then 0xA1.
  - With DEPTH=2, eof is on beat 3 only.
